// File: rtl/riscv_pkg.sv
// Shared RISC-V M-extension definitions for the issue controller.
//   m_func_t         : {idata[30], idata[25], funct3}; idata[25]=1 for every M op
//   m_issue_state_t  : issue controller FSM states
//   OPC_OP/F7_MULDIV : opcode/funct7 that identify an M-extension R-type op
package riscv_pkg;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    MUL    = 5'b01000,
    MULH   = 5'b01001,
    MULHSU = 5'b01010,
    MULHU  = 5'b01011,
    DIV    = 5'b01100,
    DIVU   = 5'b01101,
    REM    = 5'b01110,
    REMU   = 5'b01111
  } m_func_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_DRAIN
  } m_issue_state_t;

endpackage

// File: rtl/m_special_case.sv
// Combinational RISC-V divide special-case resolver.
//   func           : decoded m_func
//   rs1, rs2       : operand values
//   is_special     : result is known without the multi-cycle responder
//   special_result : architecturally defined result for that case
module m_special_case
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  m_func_t          func,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  output logic             is_special,
  output logic [XLEN-1:0]  special_result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic div_zero, ovf;
  assign div_zero = (rs2 == '0);
  // Only signed ops can overflow: most-negative / -1
  assign ovf      = (rs1 == INT_MIN) && (rs2 == '1);

  always_comb begin
    is_special     = 1'b0;
    special_result = '0;
    case (func)
      DIV: begin
        if (div_zero) begin
          is_special     = 1'b1;
          special_result = '1;
        end else if (ovf) begin
          is_special     = 1'b1;
          special_result = INT_MIN;
        end
      end
      DIVU: begin
        if (div_zero) begin
          is_special     = 1'b1;
          special_result = '1;
        end
      end
      REM: begin
        if (div_zero) begin
          is_special     = 1'b1;
          special_result = rs1;
        end else if (ovf) begin
          is_special     = 1'b1;
          special_result = '0;
        end
      end
      REMU: begin
        if (div_zero) begin
          is_special     = 1'b1;
          special_result = rs1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/m_issue_ctrl.sv
// M-extension issue controller: detects MUL/DIV/REM at decode, latches
// operands, hands them to a multi-cycle muldiv responder over valid/ready,
// stalls the core until the result returns and writes it back once.
// Divide-by-zero and signed overflow are resolved locally (no request).
//   clk, rst            : clock, async active-high reset
//   instr_valid, idata  : decode-stage instruction
//   rv1, rv2            : register-file read data
//   flush               : discard in-flight instruction
//   stall               : high whenever not IDLE
//   req_*               : request channel to responder
//   rsp_valid, rsp_data : single-cycle result pulse from responder
//   wb_en/addr/data     : register write-back
//   err_timeout         : sticky, responder silent for TIMEOUT WAIT cycles
module m_issue_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     idata,
  input  logic [XLEN-1:0] rv1,
  input  logic [XLEN-1:0] rv2,
  input  logic            flush,
  output logic            stall,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [4:0]      req_func,
  output logic [XLEN-1:0] req_a,
  output logic [XLEN-1:0] req_b,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  m_issue_state_t  state, state_nxt;
  m_func_t         dec_func, func_q;
  logic            is_mop, accept, is_special;
  logic [XLEN-1:0] special_result;
  logic [4:0]      rd_q;
  logic [CW-1:0]   tmo_cnt;

  assign dec_func = m_func_t'({idata[30], idata[25], idata[14:12]});
  assign is_mop   = instr_valid && (idata[6:0] == OPC_OP) && (idata[31:25] == F7_MULDIV);
  assign accept   = (state == S_IDLE) && is_mop && !flush;

  m_special_case #(.XLEN(XLEN)) u_special (
    .func           (dec_func),
    .rs1            (rv1),
    .rs2            (rv2),
    .is_special     (is_special),
    .special_result (special_result)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = is_special ? S_WB : S_ISSUE;
      // Once the handshake happens the responder owes us a result, so a
      // flush in that same cycle must still drain it.
      S_ISSUE: begin
        if (req_ready)  state_nxt = flush ? S_DRAIN : S_WAIT;
        else if (flush) state_nxt = S_IDLE;
      end
      // A flush that coincides with the result has nothing left to drain.
      S_WAIT: begin
        if (flush)          state_nxt = rsp_valid ? S_IDLE : S_DRAIN;
        else if (rsp_valid) state_nxt = S_WB;
      end
      S_WB:    state_nxt = S_IDLE;
      S_DRAIN: if (rsp_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    stall     = (state != S_IDLE);
    req_valid = (state == S_ISSUE);
    wb_en     = (state == S_WB) && (rd_q != 5'd0) && !flush;
  end

  assign req_func = func_q;
  assign wb_addr  = rd_q;

  // Operand / destination / write-back registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func_q  <= m_func_t'(5'd0);
      req_a   <= '0;
      req_b   <= '0;
      rd_q    <= '0;
      wb_data <= '0;
    end else begin
      if (accept) begin
        func_q <= dec_func;
        req_a  <= rv1;
        req_b  <= rv2;
        rd_q   <= idata[11:7];
        if (is_special) wb_data <= special_result;
      end
      if (state == S_WAIT && rsp_valid && !flush) wb_data <= rsp_data;
    end
  end

  // Timeout counter: counts WAIT cycles, saturates at TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == S_ISSUE && req_ready) begin
        tmo_cnt <= '0;
      end else if (state == S_WAIT && tmo_cnt != CW'(TIMEOUT)) begin
        tmo_cnt <= tmo_cnt + CW'(1);
        if (tmo_cnt == CW'(TIMEOUT - 1)) err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_m_issue_ctrl.sv
// Self-checking bench for m_issue_ctrl: directed corner cases plus a
// randomized op stream against an arithmetic reference model.
module tb_m_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, flush, req_ready, rsp_valid;
  logic [31:0] idata, rv1, rv2, rsp_data;
  logic        stall, req_valid, wb_en, err_timeout;
  logic [4:0]  req_func, wb_addr;
  logic [31:0] req_a, req_b, wb_data;

  int errs = 0;
  int checks = 0;

  m_issue_ctrl #(.XLEN(32), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .idata(idata),
    .rv1(rv1), .rv2(rv2), .flush(flush), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_m(input logic [2:0] f, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f, rd, 7'b0110011};
  endfunction

  // Architectural result of an M op, straight from the ISA definition
  function automatic logic [31:0] ref_m(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ub, up;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = {32'b0, a} * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Drive one M op from IDLE through write-back. Inputs change at negedge,
  // outputs are sampled at negedge before driving.
  task automatic run_op(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int rdy_dly, input int lat, input string tag);
    logic [31:0] exp, resp;
    exp  = ref_m(f, a, b);
    resp = 32'd0;
    idata = mk_m(f, rd); rv1 = a; rv2 = b; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; rv1 = $urandom; rv2 = $urandom;
    if (is_fast(f, a, b)) begin
      chk({tag, ".noreq"}, 32'(req_valid), 32'd0);
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        chk({tag, ".req_valid"}, 32'(req_valid), 32'd1);
        chk({tag, ".req_a"}, req_a, a);
        chk({tag, ".req_b"}, req_b, b);
        chk({tag, ".req_func"}, 32'(req_func), 32'({2'b01, f}));
        resp = ref_m(req_func[2:0], req_a, req_b);
        if (i == rdy_dly) req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
      end
      for (int i = 1; i < lat; i++) begin
        chk({tag, ".wait_stall"}, 32'(stall), 32'd1);
        @(negedge clk);
      end
      chk({tag, ".wait_noreq"}, 32'(req_valid), 32'd0);
      rsp_valid = 1'b1; rsp_data = resp;
      @(negedge clk);
      rsp_valid = 1'b0; rsp_data = $urandom;
    end
    chk({tag, ".wb_en"}, 32'(wb_en), 32'(rd != 5'd0));
    chk({tag, ".wb_addr"}, 32'(wb_addr), 32'(rd));
    chk({tag, ".wb_data"}, wb_data, exp);
    chk({tag, ".wb_stall"}, 32'(stall), 32'd1);
    @(negedge clk);
    chk({tag, ".post_wb_en"}, 32'(wb_en), 32'd0);
    chk({tag, ".post_stall"}, 32'(stall), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ctl"}, 32'({stall, req_valid, wb_en, err_timeout}), 32'd0);
    chk({tag, ".req_func"}, 32'(req_func), 32'd0);
    chk({tag, ".req_a"}, req_a, 32'd0);
    chk({tag, ".req_b"}, req_b, 32'd0);
    chk({tag, ".wb_addr"}, 32'(wb_addr), 32'd0);
    chk({tag, ".wb_data"}, wb_data, 32'd0);
  endtask

  // Accept an op and complete the handshake; leaves the DUT in WAIT.
  task automatic to_wait(input logic [2:0] f, input logic [4:0] rd);
    idata = mk_m(f, rd); rv1 = $urandom; rv2 = $urandom | 32'd1; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    rst = 1'b1; instr_valid = 1'b0; idata = '0; rv1 = '0; rv2 = '0;
    flush = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");

    // Directed: worked examples
    run_op(3'd0, 5'd5, 32'd7, 32'hFFFF_FFFD, 0, 4, "mul7x-3");
    chk("mul7x-3.const", wb_data, 32'hFFFF_FFEB);
    run_op(3'd5, 5'd6, 32'd1234, 32'd0, 0, 1, "divu0");
    chk("divu0.const", wb_data, 32'hFFFF_FFFF);
    run_op(3'd4, 5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, "divovf");
    chk("divovf.const", wb_data, 32'h8000_0000);
    run_op(3'd6, 5'd8, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, "removf");
    run_op(3'd7, 5'd9, 32'hDEAD_BEEF, 32'd0, 0, 1, "remu0");
    run_op(3'd2, 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 3, "backpressure");
    run_op(3'd0, 5'd0, 32'd3, 32'd4, 0, 2, "rd_x0");

    // Non-M and flushed decode are ignored
    idata = {7'b0000000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011}; instr_valid = 1'b1;
    @(negedge clk);
    chk("non_m_op", 32'(stall), 32'd0);
    idata = {7'b0000001, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0010011};
    @(negedge clk);
    chk("non_m_opimm", 32'(stall), 32'd0);
    idata = mk_m(3'd0, 5'd3); flush = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; flush = 1'b0;
    chk("flush_idle", 32'({stall, req_valid}), 32'd0);

    // flush in ISSUE before handshake
    idata = mk_m(3'd1, 5'd4); rv1 = 32'd5; rv2 = 32'd6; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("flush_issue.req", 32'(req_valid), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_issue.idle", 32'({stall, req_valid}), 32'd0);

    // flush together with handshake -> drain, no write-back
    idata = mk_m(3'd1, 5'd4); instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; flush = 1'b1; req_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; req_ready = 1'b0;
    chk("flush_hs.drain", 32'({stall, req_valid}), 32'b10);
    rsp_valid = 1'b1; rsp_data = 32'h1111_1111;
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("flush_hs.idle", 32'({stall, wb_en}), 32'd0);

    // flush in WAIT, response 3 cycles later is discarded
    to_wait(3'd0, 5'd9);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("flush_wait.drain", 32'({stall, wb_en}), 32'b10);
      @(negedge clk);
    end
    rsp_valid = 1'b1; rsp_data = 32'h2222_2222;
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("flush_wait.no_wb", 32'({stall, wb_en}), 32'd0);
    run_op(3'd3, 5'd11, 32'hF000_0001, 32'h8000_0003, 1, 2, "mulhu_after_flush");

    // flush in WB suppresses the write
    idata = mk_m(3'd5, 5'd12); rv1 = 32'd9; rv2 = 32'd0; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; flush = 1'b1;
    #1;
    chk("flush_wb.wb_en", 32'(wb_en), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_wb.idle", 32'(stall), 32'd0);

    // Randomized op stream
    for (int n = 0; n < 40; n++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 20)); b = 32'($urandom_range(1, 5)); end
        default: ;
      endcase
      run_op(f, 5'($urandom_range(0, 31)), a, b,
             $urandom_range(0, 3), $urandom_range(1, 5), $sformatf("rnd%0d", n));
    end
    chk("no_timeout_yet", 32'(err_timeout), 32'd0);

    // Timeout: err rises exactly 64 WAIT cycles after the handshake
    to_wait(3'd0, 5'd13);
    repeat (63) @(negedge clk);
    chk("tmo.before", 32'(err_timeout), 32'd0);
    @(negedge clk);
    chk("tmo.at64", 32'(err_timeout), 32'd1);
    repeat (5) @(negedge clk);
    chk("tmo.sticky", 32'({err_timeout, stall}), 32'b11);
    rsp_valid = 1'b1; rsp_data = 32'h3333_3333;
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("tmo.late_wb", 32'({wb_en, err_timeout}), 32'b11);
    chk("tmo.late_data", wb_data, 32'h3333_3333);
    @(negedge clk);
    chk("tmo.still", 32'(err_timeout), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("tmo.rst");

    // Asynchronous reset in WAIT
    to_wait(3'd1, 5'd14);
    #2 rst = 1'b1;
    #1;
    chk_zero("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd0, 5'd15, 32'd100, 32'd200, 0, 1, "after_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
